eth_rx_frame_flt: RTL and testbench

//  Parametrised successor of the Ethernet frame receiver. Takes the RTL8211EG GMII byte stream, strips the

---
 rtl/eth_rx_frame_flt.sv | 258 +++++++++++++++++++++++++
 tb/tb_eth_rx_frame_flt.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_flt.sv
// GMII receive framer: strips preamble/SFD, packs bytes into 16-bit buffer words,
// filters on destination MAC and flags length/CRC/line errors.
module eth_rx_frame_flt #(
  parameter int unsigned AW     = 10,
  parameter int unsigned LW     = 11,
  parameter int unsigned MINLEN = 64,
  parameter int unsigned MAXLEN = 1518,
  parameter int unsigned PREMIN = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          rxena,
  input  logic [7:0]    datain,
  input  logic          rxdv,
  input  logic          rxer,
  input  logic [47:0]   mymac,
  input  logic          promisc,
  input  logic          allmulti,
  input  logic [31:0]   crc,
  input  logic          rxdone,
  output logic [LW-1:0] rxcntb,
  output logic [AW-1:0] rxbaddr,
  output logic [15:0]   rxbdata,
  output logic          rxwrn,
  output logic          rxrdy,
  output logic          crcen,
  output logic          crcre,
  output logic          err_gen,
  output logic          err_crc,
  output logic          err_len
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRE    = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;
  localparam logic [2:0] S_DROP   = 3'd6;

  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  logic [2:0]    state_q, state_d;
  logic [2:0]    pre_cnt_q, pre_cnt_d;
  logic          phase_q, phase_d;
  logic [7:0]    lat_q, lat_d;
  logic          uc_ok_q, uc_ok_d;
  logic          bc_ok_q, bc_ok_d;
  logic          mc_q, mc_d;
  logic          wr_any_q, wr_any_d;
  logic [LW-1:0] rxcntb_q, rxcntb_d;
  logic [AW-1:0] rxbaddr_q, rxbaddr_d;
  logic [15:0]   rxbdata_q, rxbdata_d;
  logic          rxwrn_q, rxwrn_d;
  logic          rxrdy_q, rxrdy_d;
  logic          crcen_q, crcen_d;
  logic          crcre_q, crcre_d;
  logic          err_gen_q, err_gen_d;
  logic          err_crc_q, err_crc_d;
  logic          err_len_q, err_len_d;

  logic [7:0]    mac_byte;
  logic [LW-1:0] cnt_inc;
  logic          at_max;
  logic          addr_full;
  logic          filt_fail;

  always_comb begin
    case (rxcntb_q[2:0])
      3'd0:    mac_byte = mymac[47:40];
      3'd1:    mac_byte = mymac[39:32];
      3'd2:    mac_byte = mymac[31:24];
      3'd3:    mac_byte = mymac[23:16];
      3'd4:    mac_byte = mymac[15:8];
      default: mac_byte = mymac[7:0];
    endcase
  end

  assign cnt_inc   = (rxcntb_q == '1) ? rxcntb_q : rxcntb_q + LW'(1);
  assign at_max    = rxcntb_q >= LW'(MAXLEN);
  // rxbaddr starts at all-ones so the first write lands at 0; only a later all-ones means full
  assign addr_full = wr_any_q && (rxbaddr_q == '1);

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    phase_d   = phase_q;
    lat_d     = lat_q;
    uc_ok_d   = uc_ok_q;
    bc_ok_d   = bc_ok_q;
    mc_d      = mc_q;
    wr_any_d  = wr_any_q;
    rxcntb_d  = rxcntb_q;
    rxbaddr_d = rxbaddr_q;
    rxbdata_d = rxbdata_q;
    rxwrn_d   = 1'b0;
    rxrdy_d   = rxrdy_q;
    crcen_d   = 1'b0;
    crcre_d   = crcre_q;
    err_gen_d = err_gen_q;
    err_crc_d = err_crc_q;
    err_len_d = err_len_q;
    filt_fail = 1'b0;

    case (state_q)
      S_IDLE: begin
        crcre_d   = 1'b1;
        rxcntb_d  = '0;
        rxbaddr_d = '1;
        phase_d   = 1'b0;
        wr_any_d  = 1'b0;
        rxrdy_d   = 1'b0;
        if (rxena && rxdv && datain == 8'h55) begin
          err_gen_d = 1'b0;
          err_crc_d = 1'b0;
          err_len_d = 1'b0;
          pre_cnt_d = 3'd1;
          state_d   = S_PRE;
        end
      end
      S_PRE: begin
        if (rxer || !rxdv) begin
          err_gen_d = 1'b1;
          state_d   = S_IDLE;
        end else if (datain == 8'h55) begin
          pre_cnt_d = (pre_cnt_q == 3'd7) ? pre_cnt_q : pre_cnt_q + 3'd1;
        end else if (datain == 8'hD5 && pre_cnt_q >= 3'(PREMIN)) begin
          crcre_d = 1'b0;
          state_d = S_DATA;
        end else begin
          err_gen_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DATA: begin
        crcre_d = 1'b0;
        if (rxer) begin
          err_gen_d = 1'b1;
          state_d   = S_IDLE;
        end else if (!rxdv) begin
          state_d = (rxcntb_q < LW'(6)) ? S_DROP : S_FLUSH;
        end else begin
          crcen_d  = 1'b1;
          rxcntb_d = cnt_inc;
          if (at_max) err_len_d = 1'b1;
          if (rxcntb_q < LW'(6)) begin
            uc_ok_d = ((rxcntb_q == '0) || uc_ok_q) && (datain == mac_byte);
            bc_ok_d = ((rxcntb_q == '0) || bc_ok_q) && (datain == 8'hFF);
            if (rxcntb_q == '0) mc_d = datain[0];
            filt_fail = (rxcntb_q == LW'(5)) &&
                        !(promisc || uc_ok_d || bc_ok_d || (allmulti && mc_q));
          end
          if (filt_fail) begin
            state_d = S_DROP;
          end else if (!phase_q) begin
            lat_d   = datain;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (at_max || addr_full) begin
              err_len_d = 1'b1;
            end else begin
              rxbdata_d = {lat_q, datain};
              rxbaddr_d = rxbaddr_q + AW'(1);
              rxwrn_d   = 1'b1;
              wr_any_d  = 1'b1;
            end
          end
        end
      end
      S_FLUSH: begin
        if (phase_q) begin
          if (rxcntb_q > LW'(MAXLEN) || addr_full) begin
            err_len_d = 1'b1;
          end else begin
            rxbdata_d = {lat_q, 8'h00};
            rxbaddr_d = rxbaddr_q + AW'(1);
            rxwrn_d   = 1'b1;
            wr_any_d  = 1'b1;
          end
        end
        phase_d = 1'b0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (crc != CRC_RESIDUE) err_crc_d = 1'b1;
        if (rxcntb_q < LW'(MINLEN)) err_len_d = 1'b1;
        rxcntb_d = (rxcntb_q >= LW'(4)) ? rxcntb_q - LW'(4) : '0;
        state_d  = S_FINISH;
      end
      S_FINISH: begin
        rxrdy_d = 1'b1;
        if (rxdone && rxrdy_q) begin
          rxrdy_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (!rxdv) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= '0;
      phase_q   <= 1'b0;
      lat_q     <= '0;
      uc_ok_q   <= 1'b0;
      bc_ok_q   <= 1'b0;
      mc_q      <= 1'b0;
      wr_any_q  <= 1'b0;
      rxcntb_q  <= '0;
      rxbaddr_q <= '1;
      rxbdata_q <= '0;
      rxwrn_q   <= 1'b0;
      rxrdy_q   <= 1'b0;
      crcen_q   <= 1'b0;
      crcre_q   <= 1'b1;
      err_gen_q <= 1'b0;
      err_crc_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      phase_q   <= phase_d;
      lat_q     <= lat_d;
      uc_ok_q   <= uc_ok_d;
      bc_ok_q   <= bc_ok_d;
      mc_q      <= mc_d;
      wr_any_q  <= wr_any_d;
      rxcntb_q  <= rxcntb_d;
      rxbaddr_q <= rxbaddr_d;
      rxbdata_q <= rxbdata_d;
      rxwrn_q   <= rxwrn_d;
      rxrdy_q   <= rxrdy_d;
      crcen_q   <= crcen_d;
      crcre_q   <= crcre_d;
      err_gen_q <= err_gen_d;
      err_crc_q <= err_crc_d;
      err_len_q <= err_len_d;
    end
  end

  assign rxcntb  = rxcntb_q;
  assign rxbaddr = rxbaddr_q;
  assign rxbdata = rxbdata_q;
  assign rxwrn   = rxwrn_q;
  assign rxrdy   = rxrdy_q;
  assign crcen   = crcen_q;
  assign crcre   = crcre_q;
  assign err_gen = err_gen_q;
  assign err_crc = err_crc_q;
  assign err_len = err_len_q;

endmodule

// File: tb/tb_eth_rx_frame_flt.sv
// Bench for eth_rx_frame_flt: directed and randomized frames against a frame-level reference model.
module tb_eth_rx_frame_flt;

  localparam int MINLEN = 64;
  localparam int MAXLEN = 1518;

  logic        clk = 1'b0;
  logic        clr, rxena, rxdv, rxer, promisc, allmulti, rxdone;
  logic [7:0]  datain;
  logic [47:0] mymac;
  logic [31:0] crc;
  logic [10:0] rxcntb;
  logic [9:0]  rxbaddr;
  logic [15:0] rxbdata;
  logic        rxwrn, rxrdy, crcen, crcre, err_gen, err_crc, err_len;

  int checks = 0;
  int failures = 0;

  logic [7:0]  fb [0:2047];
  logic [25:0] wq[$];
  logic [25:0] exp_w[$];
  bit          rdy_seen;
  bit          exp_rdy, exp_gen, exp_crc, exp_len, mid_chk;
  int          exp_cnt;

  always #5 clk = ~clk;

  eth_rx_frame_flt #(.AW(10), .LW(11), .MINLEN(MINLEN), .MAXLEN(MAXLEN), .PREMIN(1)) dut (
    .clk(clk), .clr(clr), .rxena(rxena), .datain(datain), .rxdv(rxdv), .rxer(rxer),
    .mymac(mymac), .promisc(promisc), .allmulti(allmulti), .crc(crc), .rxdone(rxdone),
    .rxcntb(rxcntb), .rxbaddr(rxbaddr), .rxbdata(rxbdata), .rxwrn(rxwrn), .rxrdy(rxrdy),
    .crcen(crcen), .crcre(crcre), .err_gen(err_gen), .err_crc(err_crc), .err_len(err_len)
  );

  // DUT moves on the falling edge; the bench drives and samples on the rising edge.
  always @(posedge clk) begin
    if (rxwrn === 1'b1) wq.push_back({rxbaddr, rxbdata});
    if (rxrdy === 1'b1) rdy_seen = 1'b1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".rxrdy"}, rxrdy, 0);
    chk({tag, ".rxwrn"}, rxwrn, 0);
    chk({tag, ".crcen"}, crcen, 0);
    chk({tag, ".crcre"}, crcre, 1);
    chk({tag, ".rxcntb"}, rxcntb, 0);
    chk({tag, ".rxbaddr"}, rxbaddr, 10'h3FF);
    chk({tag, ".err_gen"}, err_gen, 0);
    chk({tag, ".err_crc"}, err_crc, 0);
    chk({tag, ".err_len"}, err_len, 0);
  endtask

  task automatic drv(input logic [7:0] b, input logic dv, input logic er);
    @(posedge clk);
    datain = b;
    rxdv   = dv;
    rxer   = er;
  endtask

  // kind: 0 own MAC, 1 broadcast, 2 multicast 01:00:5E:00:00:01, 3 foreign unicast
  task automatic fill_frame(input int len, input int kind);
    logic [47:0] d;
    case (kind)
      0:       d = mymac;
      1:       d = 48'hFFFF_FFFF_FFFF;
      2:       d = 48'h0100_5E00_0001;
      default: d = mymac ^ 48'h0000_0000_0001;
    endcase
    for (int k = 0; k < 6; k++) fb[k] = d[47-8*k -: 8];
    for (int k = 6; k < len; k++) fb[k] = 8'($urandom);
  endtask

  task automatic model(input int len, input int er_at, input bit crc_ok);
    logic [47:0] d;
    bit pass;
    int nw;
    d = '0;
    for (int k = 0; k < 6; k++) d = {d[39:0], fb[k]};
    pass = promisc || (d == mymac) || (d == 48'hFFFF_FFFF_FFFF) || (allmulti && d[40]);
    exp_rdy = 0; exp_gen = 0; exp_crc = 0; exp_len = 0; exp_cnt = 0;
    mid_chk = pass && (len > 9) && (er_at < 0 || er_at > 8);
    exp_w.delete();
    if (!pass) begin
      nw = 2;
    end else if (er_at >= 0) begin
      exp_gen = 1;
      nw = er_at / 2;
    end else begin
      exp_rdy = 1;
      nw = ((len < MAXLEN) ? len : MAXLEN) / 2 + (((len % 2) == 1 && len <= MAXLEN) ? 1 : 0);
      exp_cnt = (len > 4) ? len - 4 : 0;
      exp_len = (len < MINLEN) || (len > MAXLEN);
      exp_crc = !crc_ok;
    end
    for (int w = 0; w < nw; w++)
      exp_w.push_back({10'(w), fb[2*w], (2*w+1 < len) ? fb[2*w+1] : 8'h00});
  endtask

  task automatic send(input int npre, input int len, input int er_at);
    wq.delete();
    rdy_seen = 0;
    for (int i = 0; i < npre; i++) drv(8'h55, 1'b1, 1'b0);
    drv(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < len; i++) begin
      drv(fb[i], 1'b1, i == er_at);
      if (i == er_at) break;
      if (i == 8 && mid_chk) begin
        chk("mid.crcen", crcen, 1);
        chk("mid.crcre", crcre, 0);
      end
    end
    drv(8'h00, 1'b0, 1'b0);
  endtask

  task automatic expect_frame(input string tag);
    int n;
    int m;
    if (exp_rdy) begin
      n = 0;
      while (rxrdy !== 1'b1 && n < 20) begin
        @(posedge clk);
        n++;
      end
      chk({tag, ".latency"}, n, 4);
      chk({tag, ".rxcntb"}, rxcntb, exp_cnt);
    end else begin
      repeat (8) @(posedge clk);
      chk({tag, ".no_rdy"}, rdy_seen, 0);
    end
    chk({tag, ".err_gen"}, err_gen, exp_gen);
    chk({tag, ".err_crc"}, err_crc, exp_crc);
    chk({tag, ".err_len"}, err_len, exp_len);
    chk({tag, ".nwords"}, wq.size(), exp_w.size());
    m = (wq.size() < exp_w.size()) ? wq.size() : exp_w.size();
    for (int i = 0; i < m; i++) chk($sformatf("%s.w%0d", tag, i), wq[i], exp_w[i]);
    if (exp_rdy) begin
      @(posedge clk); rxdone = 1'b1;
      @(posedge clk); rxdone = 1'b0;
      repeat (2) @(posedge clk);
      chk({tag, ".rdy_clr"}, rxrdy, 0);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic run(input string tag, input int npre, input int len, input int kind,
                     input int er_at, input bit crc_ok);
    crc = crc_ok ? 32'hC704DD7B : (32'hC704DD7B ^ (32'h1 << $urandom_range(0, 31)));
    fill_frame(len, kind);
    model(len, er_at, crc_ok);
    send(npre, len, er_at);
    expect_frame(tag);
  endtask

  initial begin
    clr = 1'b1; rxena = 1'b1; rxdv = 1'b0; rxer = 1'b0; datain = 8'h00;
    promisc = 1'b0; allmulti = 1'b0; rxdone = 1'b0; crc = 32'hC704DD7B;
    mymac = {8'($urandom) & 8'hFE, 8'($urandom), 32'($urandom)};
    repeat (3) @(posedge clk);
    clr = 1'b0;
    @(posedge clk);
    chk_reset("reset");

    run("t1_unicast64", 7, 64, 0, -1, 1'b1);
    run("t2_bcast65", 7, 65, 1, -1, 1'b1);
    run("t3_mcast_drop", 7, 64, 2, -1, 1'b1);
    allmulti = 1'b1;
    run("t3_mcast_ok", 7, 64, 2, -1, 1'b1);
    allmulti = 1'b0;
    run("foreign_drop", 3, 70, 3, -1, 1'b1);
    promisc = 1'b1;
    run("foreign_promisc", 3, 70, 3, -1, 1'b1);
    promisc = 1'b0;
    run("t4_runt40", 7, 40, 0, -1, 1'b1);
    run("t4_giant1600", 7, 1600, 0, -1, 1'b1);
    run("t5_rxer10", 7, 64, 0, 10, 1'b1);
    run("t5_badcrc", 7, 64, 0, -1, 1'b0);

    // clr in the middle of the data phase
    fill_frame(64, 0);
    wq.delete();
    for (int i = 0; i < 7; i++) drv(8'h55, 1'b1, 1'b0);
    drv(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drv(fb[i], 1'b1, 1'b0);
    @(posedge clk);
    clr = 1'b1; rxdv = 1'b0;
    #1;
    chk_reset("t6_clr");
    @(posedge clk);
    clr = 1'b0;
    repeat (2) @(posedge clk);
    run("t6_after_clr", 7, 64, 0, -1, 1'b1);

    for (int it = 0; it < 10; it++) begin
      promisc  = ($urandom_range(0, 3) == 0);
      allmulti = $urandom_range(0, 1) == 1;
      run($sformatf("rnd%0d", it), $urandom_range(1, 7), $urandom_range(60, 300),
          $urandom_range(0, 3), -1, $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
